// File: rtl/rv_iommu_pkg.sv
// Shared IOMMU HPM definitions: event type encoding and the event-queue entry layout.
package rv_iommu;

  localparam int unsigned HPM_EVT_NUM = 6;

  typedef enum logic [2:0] {
    UT_REQ     = 3'd0,
    IOTLB_MISS = 3'd1,
    DDTW       = 3'd2,
    PDTW       = 3'd3,
    S1_PTW     = 3'd4,
    S2_PTW     = 3'd5
  } hpm_evt_e;

  typedef struct packed {
    hpm_evt_e      evt_type;
    logic [23:0]   did;
    logic [19:0]   pid;
    logic [19:0]   pscid;
    logic [15:0]   gscid;
    logic          pid_v;
  } hpm_evq_entry_t;

  function automatic logic [2:0] popcnt6(input logic [5:0] v);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < 6; i++) c = c + {2'b00, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/iommu_hpm_evq_fifo.sv
// Registered-output event FIFO: a pushed entry becomes visible the cycle after the push.
module iommu_hpm_evq_fifo
  import rv_iommu::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           push_i,
  input  hpm_evq_entry_t data_i,
  input  logic           pop_i,
  output hpm_evq_entry_t data_o,
  output logic           full_o,
  output logic           empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]    cnt_q, cnt_d;
  hpm_evq_entry_t mem_q [DEPTH];
  hpm_evq_entry_t mem_d [DEPTH];
  logic           do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rptr_q];

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    do_pop  = pop_i & ~empty_o;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    do_push = push_i & (~full_o | do_pop);
    if (do_push) begin
      mem_d[wptr_q] = data_i;
      wptr_d        = wptr_q + 1'b1;
    end
    if (do_pop) rptr_d = rptr_q + 1'b1;
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: rtl/iommu_hpm_evq.sv
// HPM event capture: edge-detects event lines, parks one snapshot per type, and
// feeds them by fixed priority into a small FIFO toward the HPM counters.
module iommu_hpm_evq
  import rv_iommu::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DROP_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic [5:0]        evt_i,
  input  logic [23:0]       did_i,
  input  logic [19:0]       pid_i,
  input  logic [19:0]       pscid_i,
  input  logic [15:0]       gscid_i,
  input  logic              pid_v_i,
  output logic              evt_valid_o,
  input  logic              evt_ready_i,
  output logic [2:0]        evt_type_o,
  output logic [23:0]       did_o,
  output logic [19:0]       pid_o,
  output logic [19:0]       pscid_o,
  output logic [15:0]       gscid_o,
  output logic              pid_v_o,
  output logic [DROP_W-1:0] drop_cnt_o
);

  localparam int unsigned NE = HPM_EVT_NUM;

  logic [NE-1:0]     evt_q, evt_d, pend_q, pend_d;
  logic [NE-1:0]     edge_v, xfer, drop_v;
  hpm_evq_entry_t    snap_q [NE];
  hpm_evq_entry_t    snap_d [NE];
  hpm_evq_entry_t    push_data, head, out_e;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [DROP_W+2:0] drop_sum;
  logic [2:0]        sel;
  logic              push, pop, can_push, fifo_full, fifo_empty, fifo_valid;

  assign fifo_valid = ~fifo_empty;
  assign pop        = fifo_valid & evt_ready_i;
  assign can_push   = ~fifo_full | pop;

  always_comb begin
    evt_d  = evt_i;
    edge_v = evt_i & ~evt_q & {NE{en_i}};
    sel    = '0;
    for (int i = NE - 1; i >= 0; i--) begin
      if (pend_q[i]) sel = 3'(i);
    end
    push      = can_push & (|pend_q);
    xfer      = '0;
    if (push) xfer[sel] = 1'b1;
    push_data = snap_q[sel];

    pend_d = pend_q;
    snap_d = snap_q;
    drop_v = '0;
    // A slot leaving this cycle is free to take a new snapshot; otherwise the old one wins.
    for (int i = 0; i < NE; i++) begin
      if (xfer[i]) pend_d[i] = 1'b0;
      if (edge_v[i]) begin
        if (pend_q[i] && !xfer[i]) begin
          drop_v[i] = 1'b1;
        end else begin
          pend_d[i] = 1'b1;
          snap_d[i] = '{evt_type: hpm_evt_e'(3'(i)), did: did_i, pid: pid_i,
                        pscid: pscid_i, gscid: gscid_i, pid_v: pid_v_i};
        end
      end
    end

    drop_sum = {3'b000, drop_q} + {{DROP_W{1'b0}}, popcnt6(drop_v)};
    drop_d   = (|drop_sum[DROP_W+2:DROP_W]) ? '1 : drop_sum[DROP_W-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      evt_q  <= '0;
      pend_q <= '0;
      drop_q <= '0;
      for (int i = 0; i < NE; i++) snap_q[i] <= '0;
    end else begin
      evt_q  <= evt_d;
      pend_q <= pend_d;
      drop_q <= drop_d;
      snap_q <= snap_d;
    end
  end

  iommu_hpm_evq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_e       = fifo_valid ? head : '0;
  assign evt_valid_o = fifo_valid;
  assign evt_type_o  = out_e.evt_type;
  assign did_o       = out_e.did;
  assign pid_o       = out_e.pid;
  assign pscid_o     = out_e.pscid;
  assign gscid_o     = out_e.gscid;
  assign pid_v_o     = out_e.pid_v;
  assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_iommu_hpm_evq.sv
// Directed bench for iommu_hpm_evq; a second instance with a 2-bit drop counter shares all inputs.
module tb_iommu_hpm_evq;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        en_i;
  logic [5:0]  evt_i;
  logic [23:0] did_i;
  logic [19:0] pid_i, pscid_i;
  logic [15:0] gscid_i;
  logic        pid_v_i;
  logic        evt_ready_i;

  logic        evt_valid_o, pid_v_o;
  logic [2:0]  evt_type_o;
  logic [23:0] did_o;
  logic [19:0] pid_o, pscid_o;
  logic [15:0] gscid_o;
  logic [7:0]  drop_cnt_o;

  logic        s_valid, s_pid_v;
  logic [2:0]  s_type;
  logic [23:0] s_did;
  logic [19:0] s_pid, s_pscid;
  logic [15:0] s_gscid;
  logic [1:0]  s_drop;

  int errors = 0;
  int checks = 0;

  logic [2:0]  exp_t [10];
  logic [23:0] exp_d [10];

  always #5 clk_i = ~clk_i;

  iommu_hpm_evq u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .evt_i(evt_i),
    .did_i(did_i), .pid_i(pid_i), .pscid_i(pscid_i), .gscid_i(gscid_i), .pid_v_i(pid_v_i),
    .evt_valid_o(evt_valid_o), .evt_ready_i(evt_ready_i), .evt_type_o(evt_type_o),
    .did_o(did_o), .pid_o(pid_o), .pscid_o(pscid_o), .gscid_o(gscid_o), .pid_v_o(pid_v_o),
    .drop_cnt_o(drop_cnt_o)
  );

  iommu_hpm_evq #(.DEPTH(4), .DROP_W(2)) u_sat (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .evt_i(evt_i),
    .did_i(did_i), .pid_i(pid_i), .pscid_i(pscid_i), .gscid_i(gscid_i), .pid_v_i(pid_v_i),
    .evt_valid_o(s_valid), .evt_ready_i(evt_ready_i), .evt_type_o(s_type),
    .did_o(s_did), .pid_o(s_pid), .pscid_o(s_pscid), .gscid_o(s_gscid), .pid_v_o(s_pid_v),
    .drop_cnt_o(s_drop)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_ni = 1'b0; en_i = 1'b1; evt_i = '0; evt_ready_i = 1'b1;
    did_i = '0; pid_i = '0; pscid_i = '0; gscid_i = '0; pid_v_i = 1'b0;
    tick(); tick();
    check("rst_valid", 32'(evt_valid_o), 32'd0);
    check("rst_type",  32'(evt_type_o), 32'd0);
    check("rst_did",   32'(did_o), 32'd0);
    check("rst_drop",  32'(drop_cnt_o), 32'd0);
    rst_ni = 1'b1;
    tick();

    // single IOTLB_MISS edge, two-cycle latency
    evt_i = 6'b000010; did_i = 24'h00ABCD; pid_i = 20'h12345; pscid_i = 20'h0BCDE;
    gscid_i = 16'hBEEF; pid_v_i = 1'b1;
    tick();
    check("t1_n1_valid", 32'(evt_valid_o), 32'd0);
    evt_i = '0; did_i = 24'hFFFFFF; pid_i = '0; pscid_i = '0; gscid_i = '0; pid_v_i = 1'b0;
    tick();
    check("t1_valid", 32'(evt_valid_o), 32'd1);
    check("t1_type",  32'(evt_type_o), 32'd1);
    check("t1_did",   32'(did_o), 32'h00ABCD);
    check("t1_pid",   32'(pid_o), 32'h12345);
    check("t1_pscid", 32'(pscid_o), 32'h0BCDE);
    check("t1_gscid", 32'(gscid_o), 32'hBEEF);
    check("t1_pidv",  32'(pid_v_o), 32'd1);
    tick();
    check("t1_after_valid", 32'(evt_valid_o), 32'd0);
    check("t1_after_did",   32'(did_o), 32'd0);

    // all six types at once drain in priority order
    did_i = 24'h000222; evt_i = 6'b111111;
    tick();
    evt_i = '0;
    tick();
    for (int k = 0; k < 6; k++) begin
      check("t2_valid", 32'(evt_valid_o), 32'd1);
      check("t2_type",  32'(evt_type_o), 32'(k));
      tick();
    end
    check("t2_end_valid", 32'(evt_valid_o), 32'd0);
    check("t2_drop", 32'(drop_cnt_o), 32'd0);

    // ten UT_REQ pulses with the consumer stalled
    evt_ready_i = 1'b0;
    for (int p = 0; p < 10; p++) begin
      evt_i = 6'b000001; did_i = 24'h000100 + 24'(p);
      tick();
      evt_i = '0;
      tick();
    end
    check("t3_head_valid", 32'(evt_valid_o), 32'd1);
    check("t3_head_did",   32'(did_o), 32'h000100);
    tick();
    check("t3_stable_did", 32'(did_o), 32'h000100);
    check("t3_drop",       32'(drop_cnt_o), 32'd5);
    check("t3_sat_drop",   32'(s_drop), 32'd3);
    evt_ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("t3_out_valid", 32'(evt_valid_o), 32'd1);
      check("t3_out_did",   32'(did_o), 32'h000100 + 32'(k));
      tick();
    end
    check("t3_end_valid", 32'(evt_valid_o), 32'd0);

    // multiple drops in one cycle; old snapshots of still-pending slots survive
    evt_ready_i = 1'b0;
    did_i = 24'h000111; evt_i = 6'b111111;
    tick();
    evt_i = '0;
    repeat (5) tick();
    did_i = 24'h000222; evt_i = 6'b111111;
    tick();
    check("t4_drop_two", 32'(drop_cnt_o), 32'd7);
    evt_i = '0;
    tick();
    did_i = 24'h000333; evt_i = 6'b111111;
    tick();
    evt_i = '0;
    check("t4_drop_six", 32'(drop_cnt_o), 32'd13);
    check("t4_sat_drop", 32'(s_drop), 32'd3);
    exp_t = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    exp_d = '{24'h111, 24'h111, 24'h111, 24'h111, 24'h222, 24'h222, 24'h222, 24'h222,
              24'h111, 24'h111};
    evt_ready_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check("t4_valid", 32'(evt_valid_o), 32'd1);
      check("t4_type",  32'(evt_type_o), 32'(exp_t[k]));
      check("t4_did",   32'(did_o), 32'(exp_d[k]));
      tick();
    end
    check("t4_end_valid", 32'(evt_valid_o), 32'd0);

    // new edge on a slot in the very cycle it moves into a full-but-popping FIFO
    evt_ready_i = 1'b0;
    for (int p = 1; p <= 5; p++) begin
      evt_i = 6'b000001; did_i = 24'(p);
      tick();
      evt_i = '0;
      tick();
    end
    evt_ready_i = 1'b1; evt_i = 6'b000001; did_i = 24'd6;
    check("t5_head_did", 32'(did_o), 32'd1);
    tick();
    evt_i = '0;
    for (int k = 2; k <= 6; k++) begin
      check("t5_valid", 32'(evt_valid_o), 32'd1);
      check("t5_did",   32'(did_o), 32'(k));
      tick();
    end
    check("t5_end_valid", 32'(evt_valid_o), 32'd0);
    check("t5_drop", 32'(drop_cnt_o), 32'd13);

    // capture disabled
    en_i = 1'b0;
    evt_i = 6'b111111; tick(); evt_i = '0; tick();
    evt_i = 6'b111111; tick(); evt_i = '0; tick(); tick();
    check("t6_off_valid", 32'(evt_valid_o), 32'd0);
    check("t6_off_drop",  32'(drop_cnt_o), 32'd13);
    evt_i = 6'b000001; tick();
    en_i = 1'b1; tick(); tick(); tick();
    check("t6_held_level", 32'(evt_valid_o), 32'd0);
    evt_i = '0; tick();
    evt_ready_i = 1'b0; evt_i = 6'b000100; did_i = 24'h000333;
    tick();
    evt_i = '0; en_i = 1'b0;
    tick(); tick();
    evt_i = 6'b111111; tick(); evt_i = '0; tick();
    check("t6_q_valid", 32'(evt_valid_o), 32'd1);
    check("t6_q_type",  32'(evt_type_o), 32'd2);
    check("t6_q_did",   32'(did_o), 32'h000333);
    check("t6_q_drop",  32'(drop_cnt_o), 32'd13);
    evt_ready_i = 1'b1;
    tick();
    check("t6_drained", 32'(evt_valid_o), 32'd0);
    en_i = 1'b1;

    // asynchronous reset with queued entries
    evt_ready_i = 1'b0; evt_i = 6'b000111; did_i = 24'h000777;
    tick();
    evt_i = '0;
    repeat (4) tick();
    check("t7_pre_valid", 32'(evt_valid_o), 32'd1);
    #3 rst_ni = 1'b0;
    #1;
    check("t7_rst_valid", 32'(evt_valid_o), 32'd0);
    check("t7_rst_did",   32'(did_o), 32'd0);
    check("t7_rst_drop",  32'(drop_cnt_o), 32'd0);
    check("t7_rst_sdrop", 32'(s_drop), 32'd0);
    tick(); tick();
    rst_ni = 1'b1; evt_ready_i = 1'b1;
    repeat (4) tick();
    check("t7_no_stale", 32'(evt_valid_o), 32'd0);
    check("t7_drop",     32'(drop_cnt_o), 32'd0);

    // line already high at reset release counts as an edge
    rst_ni = 1'b0; evt_i = 6'b001000; did_i = 24'h00CAFE;
    tick();
    rst_ni = 1'b1;
    tick();
    check("t8_n1_valid", 32'(evt_valid_o), 32'd0);
    tick();
    check("t8_valid", 32'(evt_valid_o), 32'd1);
    check("t8_type",  32'(evt_type_o), 32'd3);
    check("t8_did",   32'(did_o), 32'h00CAFE);
    evt_i = '0;
    tick();
    check("t8_end_valid", 32'(evt_valid_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iommu_hpm_evq.md
IOMMU_HPM_EVQ -- requirements
Module: iommu_hpm_evq

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning event FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter DROP_W, default 8, meaning width of the dropped-event counter.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock. All state is sampled on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port en_i, input, 1 bit: capture enable. Low when HPM is absent or all counters are inhibited.
REQ-006 SHALL have port evt_i, input, 6 bits: level event indicators, one bit per type.
- Bit order: UT_REQ, IOTLB_MISS, DDTW, PDTW, S1_PTW, S2_PTW, with UT_REQ at bit 0.
REQ-007 SHALL have the following ID input ports, sampled together with the event:
- did_i, input, 24 bits
- pid_i, input, 20 bits
- pscid_i, input, 20 bits
- gscid_i, input, 16 bits
- pid_v_i, input, 1 bit
REQ-008 SHALL have port evt_valid_o, output, 1 bit: a buffered event is presented.
REQ-009 SHALL have port evt_ready_i, input, 1 bit: the HPM consumer accepts the presented event.
REQ-010 SHALL have port evt_type_o, output, 3 bits: event type in the shared encoding.
REQ-011 SHALL have the following output ports carrying the IDs of the presented event:
- did_o, 24 bits
- pid_o, 20 bits
- pscid_o, 20 bits
- gscid_o, 16 bits
- pid_v_o, 1 bit
REQ-012 SHALL have port drop_cnt_o, output, DROP_W bits: saturating count of lost events.

Function
REQ-013 Rising-edge detection: evt_i[t] high in cycle N with a registered previous value of low SHALL be a new event. Level-high duration beyond one cycle SHALL NOT create further events.
REQ-014 Each of the 6 types SHALL own one holding slot: a pending bit plus the ID snapshot taken in the edge cycle.
REQ-015 Arbitration SHALL be fixed priority, lowest type index first. At most one slot moves into the FIFO per cycle, and only if the FIFO is not full.
REQ-016 Latency: an edge in cycle N on an empty, idle block SHALL present evt_valid_o=1 in cycle N+2 with the captured IDs.
REQ-017 Handshake: an entry SHALL pop on evt_valid_o & evt_ready_i. While evt_ready_i=0, outputs SHALL hold stable.
REQ-018 Edge on type t while slot t is pending and not transferred in that cycle: the new event SHALL be dropped, the old snapshot kept, and drop_cnt_o incremented.
REQ-019 Edge on type t in the same cycle slot t transfers: the new snapshot SHALL be captured and pending stays 1; no drop.
REQ-020 Multiple drops in one cycle SHALL add the number dropped (0..6). drop_cnt_o SHALL saturate at all-ones with no wrap.
REQ-021 FIFO full: slots SHALL hold and no push occurs. Simultaneous pop and push on a full FIFO SHALL be allowed.
REQ-022 FIFO pointers SHALL wrap modulo DEPTH. The occupancy counter SHALL be log2(DEPTH)+1 bits.
REQ-023 en_i=0: new edges SHALL be ignored, with no capture and no drop count. Already pending slots and FIFO contents SHALL still drain.
REQ-024 The edge-detect register SHALL update every cycle regardless of en_i.

Reset
REQ-025 Reset SHALL clear all of the following:
- pending bits, snapshots and edge registers
- FIFO pointers and occupancy
- drop_cnt_o
REQ-026 During and after reset, outputs SHALL be: evt_valid_o=0, all ID outputs and evt_type_o 0, drop_cnt_o=0.
REQ-027 Reset asserted mid-operation SHALL discard all buffered and pending events without a drop count.
REQ-028 An event line already high at reset release SHALL count as an edge in the first cycle after release.

Structure
REQ-029 The 3-bit event type enum SHALL live in package rv_iommu, shared with the HPM counter block:
- UT_REQ=0, IOTLB_MISS=1, DDTW=2, PDTW=3, S1_PTW=4, S2_PTW=5
REQ-030 rv_iommu SHALL also hold a packed struct of {type, did, pid, pscid, gscid, pid_v} used as the FIFO entry.
REQ-031 One sub-module is natural: iommu_hpm_evq_fifo, a DEPTH-entry synchronous FIFO with full/empty flags and no fall-through.

Verification
REQ-032 Single IOTLB_MISS edge, did_i=0x00ABCD, ready=1: evt_valid_o=1 exactly in cycle N+2, evt_type_o=1, did_o=0x00ABCD, then 0 the next cycle.
REQ-033 evt_i=6'b111111 edge in one cycle, ready=1: six outputs in consecutive cycles, types 0..5 in order, drop_cnt_o=0.
REQ-034 ready=0 held, 10 distinct UT_REQ pulses spaced 2 cycles apart, DEPTH=4: expect 4 queued, 1 pending, drop_cnt_o=5. After ready=1, expect exactly 5 events in order.
REQ-035 DROP_W=2 with 6 drops forced: drop_cnt_o saturates at 3.
REQ-036 en_i=0 with pulses on all types: no evt_valid_o and drop_cnt_o=0. A queued entry present before en_i fell still drains.
REQ-037 rst_ni asserted with 3 queued entries: evt_valid_o=0 immediately (asynchronous reset). After release, no stale events appear.
